// File: rtl/spi_slave_ctrl_if.sv
// Bus bundle for spi_slave_ctrl: SPI pins plus the parallel transmit/receive side.
// The tx_underrun signal exists only when SPI_SLAVE_UNDERRUN_EN is defined.
interface spi_slave_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              sck;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              mode_select;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic              tx_underrun;

  modport slave (
    input  sck, cs_n, mosi, mode_select, tx_data, tx_load,
    output miso, tx_ready, rx_data, rx_valid, busy, tx_underrun
  );

  modport master (
    output sck, cs_n, mosi, mode_select, tx_data, tx_load,
    input  miso, tx_ready, rx_data, rx_valid, busy, tx_underrun
  );
`else
  modport slave (
    input  sck, cs_n, mosi, mode_select, tx_data, tx_load,
    output miso, tx_ready, rx_data, rx_valid, busy
  );

  modport master (
    output sck, cs_n, mosi, mode_select, tx_data, tx_load,
    input  miso, tx_ready, rx_data, rx_valid, busy
  );
`endif
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave (modes 0 and 1) with oversampled pin synchronizers, a one-word transmit
// holding register and an IDLE/SHIFT/DONE FSM. Define SPI_SLAVE_UNDERRUN_EN for tx_underrun.
module spi_slave_ctrl #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_slave_ctrl_if.slave  spi_if
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   sck_prev_q;
  logic                   cs_prev_q;
  logic                   armed_q;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_fall;
  logic sample_edge, shift_edge, last_bit;

  logic [DATA_W-1:0] hold_q;
  logic              hold_full_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic [CNT_W-1:0]  cnt_q;

  logic frame_start, do_sample, do_shift, rx_commit, busy;

  // NOTE: non-blocking assignments make each stage take the previous stage's old
  // value; blocking ones would collapse the whole chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      fill_q      <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_if.sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_if.cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_if.mosi};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      // The reset-forced idle level of cs_n must not count as a fall: only arm once a
      // real high level has propagated through the synchronizer.
      if (fill_q[SYNC_STAGES-1] && cs_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise    = sck_s & ~sck_prev_q;
  assign sck_fall    = ~sck_s & sck_prev_q;
  assign cs_fall     = armed_q & cs_prev_q & ~cs_s;
  assign sample_edge = spi_if.mode_select ? sck_fall : sck_rise;
  assign shift_edge  = spi_if.mode_select ? sck_rise : sck_fall;
  assign last_bit    = (cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cs_s) begin
          state_d = S_IDLE;
        end else if (sample_edge && last_bit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = cs_s ? S_IDLE : S_SHIFT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    frame_start = 1'b0;
    do_sample   = 1'b0;
    do_shift    = 1'b0;
    rx_commit   = 1'b0;
    busy        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        frame_start = cs_fall;
      end
      S_SHIFT: begin
        busy      = 1'b1;
        do_sample = ~cs_s & sample_edge;
        // The shift edge before the first sample only presents the MSB, which the
        // frame-start load already did; this also skips the trailing mode-0 fall.
        do_shift  = ~cs_s & shift_edge & (cnt_q != '0);
      end
      S_DONE: begin
        rx_commit   = 1'b1;
        frame_start = ~cs_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      cnt_q       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      rx_valid_q <= rx_commit;
      if (rx_commit) begin
        rx_data_q <= rx_shift_q;
      end

      if (spi_if.tx_load) begin
        hold_q      <= spi_if.tx_data;
        hold_full_q <= 1'b1;
      end

      if (frame_start) begin
        // A load landing on the frame-start cycle goes straight out and leaves the holder empty.
        if (spi_if.tx_load) begin
          tx_shift_q <= spi_if.tx_data;
        end else if (hold_full_q) begin
          tx_shift_q <= hold_q;
        end else begin
          tx_shift_q <= '0;
        end
        hold_full_q <= 1'b0;
        cnt_q       <= '0;
      end else begin
        if (do_shift) begin
          tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
        end
        if (do_sample) begin
          rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
          cnt_q      <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q <= 1'b0;
    end else if (spi_if.tx_load) begin
      underrun_q <= 1'b0;
    end else if (frame_start && !hold_full_q) begin
      underrun_q <= 1'b1;
    end
  end

  assign spi_if.tx_underrun = underrun_q;
`endif

  assign spi_if.miso     = (state_q != S_IDLE) & ~cs_s & tx_shift_q[DATA_W-1];
  assign spi_if.tx_ready = ~hold_full_q;
  assign spi_if.rx_data  = rx_data_q;
  assign spi_if.rx_valid = rx_valid_q;
  assign spi_if.busy     = busy;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl: directed frames plus randomized frames checked
// against a word-level model; received words flow through a scoreboard queue.
module tb_spi_slave_ctrl;

  localparam int DW   = 8;
  localparam int SYNC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int cyc             = 0;
  int last_sample_cyc = 0;
  int n_tests         = 0;
  int n_fail          = 0;

  spi_slave_ctrl_if #(.DATA_W(DW)) bus ();

  spi_slave_ctrl #(
    .DATA_W      (DW),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .spi_if (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word-level model of the transmit holder and receive history.
  logic [DW-1:0] m_hold;
  bit            m_full;
  logic [DW-1:0] m_last_rx;
  logic [DW-1:0] cur_exp_tx;
`ifdef SPI_SLAVE_UNDERRUN_EN
  bit            m_underrun;
`endif
  logic [DW-1:0] exp_rx[$];
  logic [DW-1:0] e_rx;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_load(input logic [DW-1:0] d);
    m_hold = d;
    m_full = 1'b1;
`ifdef SPI_SLAVE_UNDERRUN_EN
    m_underrun = 1'b0;
`endif
  endfunction

  function automatic void model_start();
    if (m_full) begin
      cur_exp_tx = m_hold;
    end else begin
      cur_exp_tx = '0;
`ifdef SPI_SLAVE_UNDERRUN_EN
      m_underrun = 1'b1;
`endif
    end
    m_full = 1'b0;
  endfunction

  function automatic void model_reset();
    m_full    = 1'b0;
    m_hold    = '0;
    m_last_rx = '0;
`ifdef SPI_SLAVE_UNDERRUN_EN
    m_underrun = 1'b0;
`endif
  endfunction

  // A completed frame: expected word goes to the scoreboard, and since cs_n is still
  // low the slave immediately opens the next frame.
  function automatic void frame_done(input logic [DW-1:0] w);
    last_sample_cyc = cyc;
    exp_rx.push_back(w);
    m_last_rx = w;
    model_start();
  endfunction

  // Scoreboard monitor: every rx_valid pulse must match the oldest expected word.
  always @(posedge clk) begin
    #1;
    if (bus.rx_valid === 1'b1) begin
      if (exp_rx.size() == 0) begin
        check("rx_valid_unexpected", 32'(bus.rx_valid), 32'd0);
      end else begin
        e_rx = exp_rx.pop_front();
        check("rx_data", 32'(bus.rx_data), 32'(e_rx));
        check("rx_latency", 32'(cyc - last_sample_cyc), 32'(SYNC + 2));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [DW-1:0] d);
    @(negedge clk);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    model_load(d);
    @(negedge clk);
    bus.tx_load = 1'b0;
  endtask

  task automatic cs_drop(input bit coinc, input logic [DW-1:0] d);
    @(negedge clk);
    bus.cs_n = 1'b0;
    if (coinc) begin
      // Lands the load on the cycle the synchronized fall is acted upon.
      repeat (SYNC) @(negedge clk);
      bus.tx_data = d;
      bus.tx_load = 1'b1;
      model_load(d);
      @(negedge clk);
      bus.tx_load = 1'b0;
    end
    model_start();
  endtask

  task automatic shift_bits(input logic [DW-1:0] w, input int nbits, input int half,
                            input bit mid_load, input logic [DW-1:0] mid_data);
    logic [DW-1:0] exp_tx;
    logic [DW-1:0] got;
    exp_tx = cur_exp_tx;
    got    = '0;
    for (int i = 0; i < nbits; i++) begin
      if (mid_load && i == 3) pulse_load(mid_data);
      if (!bus.mode_select) begin
        bus.mosi = w[DW-1-i];
        wait_clks(half);
        bus.sck = 1'b1;
        got = {got[DW-2:0], bus.miso};
        if (i == nbits - 1 && nbits == DW) frame_done(w);
        wait_clks(half);
        bus.sck = 1'b0;
      end else begin
        wait_clks(half);
        bus.sck  = 1'b1;
        bus.mosi = w[DW-1-i];
        wait_clks(half);
        got = {got[DW-2:0], bus.miso};
        bus.sck = 1'b0;
        if (i == nbits - 1 && nbits == DW) frame_done(w);
      end
    end
    check("miso_word", 32'(got), 32'(exp_tx >> (DW - nbits)));
  endtask

  task automatic cs_raise();
    @(negedge clk);
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    bus.sck  = 1'b0;
    wait_clks(8);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_miso", 32'(bus.miso), 32'd0);
    check("tx_ready", 32'(bus.tx_ready), 32'(!m_full));
    check("rx_data_held", 32'(bus.rx_data), 32'(m_last_rx));
`ifdef SPI_SLAVE_UNDERRUN_EN
    check("tx_underrun", 32'(bus.tx_underrun), 32'(m_underrun));
`endif
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_miso"}, 32'(bus.miso), 32'd0);
    check({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'd1);
    check({tag, "_rx_data"}, 32'(bus.rx_data), 32'd0);
    check({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
`ifdef SPI_SLAVE_UNDERRUN_EN
    check({tag, "_tx_underrun"}, 32'(bus.tx_underrun), 32'd0);
`endif
  endtask

  task automatic run_frame(input bit mode, input bit do_load, input logic [DW-1:0] tx,
                           input logic [DW-1:0] w, input int nbits, input int half,
                           input bit coinc, input logic [DW-1:0] cdata);
    @(negedge clk);
    bus.mode_select = mode;
    if (do_load) pulse_load(tx);
    cs_drop(coinc, cdata);
    shift_bits(w, nbits, half, 1'b0, '0);
    cs_raise();
  endtask

  initial begin
    bus.sck         = 1'b0;
    bus.cs_n        = 1'b1;
    bus.mosi        = 1'b0;
    bus.mode_select = 1'b0;
    bus.tx_data     = '0;
    bus.tx_load     = 1'b0;
    cur_exp_tx      = '0;
    model_reset();

    wait_clks(3);
    check_reset("reset");
    rst_n = 1'b1;
    wait_clks(10);

    // Mode 0 at clk/100, then an aborted partial frame, then a clean 0x55.
    run_frame(1'b0, 1'b1, 8'hA5, 8'h3C, 8, 50, 1'b0, '0);
    run_frame(1'b0, 1'b1, 8'h99, 8'hAA, 5, 8, 1'b0, '0);
    run_frame(1'b0, 1'b1, 8'h0F, 8'h55, 8, 8, 1'b0, '0);

    // Mode 1.
    run_frame(1'b1, 1'b1, 8'h81, 8'h7E, 8, 8, 1'b0, '0);

    // Back-to-back frames with the second word loaded during the first.
    @(negedge clk);
    bus.mode_select = 1'b0;
    pulse_load(8'h11);
    cs_drop(1'b0, '0);
    shift_bits(8'h11, 8, 6, 1'b1, 8'h22);
    shift_bits(8'h22, 8, 6, 1'b0, '0);
    cs_raise();

    // Underrun: nothing loaded, miso must be all zeros.
    run_frame(1'b0, 1'b0, '0, 8'hB4, 8, 6, 1'b0, '0);

    // Load coinciding with frame start overrides the held word.
    run_frame(1'b0, 1'b1, 8'h5A, 8'h96, 8, 6, 1'b1, 8'hC6);

    // Reset mid-frame at bit 4 with cs_n still low across release.
    @(negedge clk);
    bus.mode_select = 1'b0;
    pulse_load(8'hE7);
    cs_drop(1'b0, '0);
    shift_bits(8'hF0, 4, 6, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    wait_clks(2);
    check_reset("mid_reset");
    rst_n = 1'b1;
    wait_clks(10);
    check("no_restart_busy", 32'(bus.busy), 32'd0);
    cs_raise();
    run_frame(1'b0, 1'b1, 8'h3C, 8'hC3, 8, 6, 1'b0, '0);

    // Randomized frames.
    for (int f = 0; f < 24; f++) begin
      logic          r_mode;
      logic          r_load;
      logic [DW-1:0] r_tx;
      logic [DW-1:0] r_w;
      int            r_bits;
      int            r_half;
      bit            r_coinc;
      r_mode  = 1'($urandom_range(0, 1));
      r_load  = ($urandom_range(0, 9) < 7);
      r_tx    = DW'($urandom);
      r_w     = DW'($urandom);
      r_bits  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, DW - 1)) : DW;
      r_half  = int'($urandom_range(4, 10));
      r_coinc = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) pulse_load(DW'($urandom));
      run_frame(r_mode, r_load, r_tx, r_w, r_bits, r_half, r_coinc, DW'($urandom));
    end

    for (int i = 0; i < 20 && exp_rx.size() != 0; i++) @(negedge clk);
    check("rx_drain", 32'(exp_rx.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
